// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and width codes for the memory port arbiter and its lane formatter.
package mem_port_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      WRITE   = 2'd2,
      RESP    = 2'd3
   } state_t;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   typedef logic [7:0] byte_lane_t [0:3];

endpackage

// File: rtl/mem_port_arbiter_lane_fmt.sv
// Combinational byte-lane formatter: load sign/zero extension and store byte merge.
module mem_lane_fmt
   import mem_port_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [31:0] wdata_i,
   input  logic [7:0]  old_i    [0:3],
   output logic [31:0] load_o,
   output logic [7:0]  merged_o [0:3]
);

   always_comb begin
      load_o = '0;
      case (funct3_i)
         F3_B:    load_o = {{24{old_i[0][7]}}, old_i[0]};
         F3_H:    load_o = {{16{old_i[1][7]}}, old_i[1], old_i[0]};
         F3_W:    load_o = {old_i[3], old_i[2], old_i[1], old_i[0]};
         F3_BU:   load_o = {24'd0, old_i[0]};
         F3_HU:   load_o = {16'd0, old_i[1], old_i[0]};
         default: load_o = '0;
      endcase
   end

   // Lanes not covered by the store width keep the bytes read back from memory.
   always_comb begin
      merged_o[0] = wdata_i[7:0];
      merged_o[1] = (funct3_i == F3_H || funct3_i == F3_W) ? wdata_i[15:8] : old_i[1];
      merged_o[2] = (funct3_i == F3_W) ? wdata_i[23:16] : old_i[2];
      merged_o[3] = (funct3_i == F3_W) ? wdata_i[31:24] : old_i[3];
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared byte-lane memory port between instruction fetch and load/store.
//   state   | meaning
//   IDLE    | no transaction; arbitrate if_req / d_req
//   RD_WAIT | down-count memory latency, then capture the read bytes
//   WRITE   | single-cycle write strobe with merged bytes
//   RESP    | ack the owner on the following edge, return to IDLE
module mem_port_arbiter
   import mem_port_pkg::*;
#(
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst_b,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ack,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [2:0]  d_funct3,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   output logic [31:0] d_rdata,
   output logic [31:0] mem_addr,
   output logic        mem_write_en,
   output logic [7:0]  mem_data_in  [0:3],
   input  logic [7:0]  mem_data_out [0:3],
   output logic        busy,
   output logic        grant_d
);

   localparam int               SC_W      = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [SC_W-1:0]  STARVE_TC = SC_W'(STARVE_MAX);
   localparam logic [2:0]       LAT_LOAD  = 3'(MEM_LAT);

   state_t            state_q, state_d;
   logic [SC_W-1:0]   starve_q, starve_d;
   logic              owner_q, owner_d;
   logic [31:0]       addr_q, addr_d;
   logic              we_q, we_d;
   logic [2:0]        f3_q, f3_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [2:0]        lat_q, lat_d;
   byte_lane_t        rbytes_q, rbytes_d;
   logic              if_ack_q, if_ack_d;
   logic              d_ack_q, d_ack_d;
   logic [31:0]       if_rdata_q, if_rdata_d;
   logic [31:0]       d_rdata_q, d_rdata_d;
   logic              mem_we_q, mem_we_d;
   byte_lane_t        mem_din_q, mem_din_d;
   logic              busy_q, busy_d;

   logic              grant_if, grant_dd, lat_tc, req_we;
   logic [2:0]        req_f3;
   logic [31:0]       load_val;
   logic [7:0]        merged [0:3];

   assign grant_if = if_req && (!d_req || starve_q == STARVE_TC);
   assign grant_dd = d_req && !grant_if;
   assign req_we   = grant_if ? 1'b0 : d_we;
   assign req_f3   = grant_if ? F3_W : d_funct3;
   assign lat_tc   = (lat_q == 3'd0);

   mem_lane_fmt u_fmt (
      .funct3_i (f3_d),
      .wdata_i  (wdata_d),
      .old_i    (rbytes_d),
      .load_o   (load_val),
      .merged_o (merged)
   );

   always_ff @(posedge clk) begin
      if (!rst_b) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (grant_if || grant_dd) begin
               if (!req_we || req_f3 == F3_B || req_f3 == F3_H) state_d = RD_WAIT;
               else if (req_f3 == F3_W)                          state_d = WRITE;
               else                                              state_d = RESP;
            end
         end
         RD_WAIT: if (lat_tc) state_d = we_q ? WRITE : RESP;
         WRITE:   state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Request latching, starvation counter and latency timer.
   always_comb begin
      starve_d = starve_q;
      owner_d  = owner_q;
      addr_d   = addr_q;
      we_d     = we_q;
      f3_d     = f3_q;
      wdata_d  = wdata_q;
      lat_d    = lat_q;
      rbytes_d = rbytes_q;
      case (state_q)
         IDLE: begin
            if (grant_if || grant_dd) begin
               owner_d = grant_dd;
               addr_d  = grant_if ? if_addr : d_addr;
               we_d    = req_we;
               f3_d    = req_f3;
               wdata_d = d_wdata;
               lat_d   = LAT_LOAD;
               if (grant_if || !if_req)      starve_d = '0;
               else if (starve_q != STARVE_TC) starve_d = starve_q + 1'b1;
            end
         end
         RD_WAIT: begin
            if (lat_tc) rbytes_d = mem_data_out;
            else        lat_d    = lat_q - 3'd1;
         end
         default: ;
      endcase
   end

   always_comb begin
      if_ack_d   = 1'b0;
      d_ack_d    = 1'b0;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      mem_din_d  = mem_din_q;
      if (state_q == RESP) begin
         if (owner_q) begin
            d_ack_d = 1'b1;
            if (!we_q) d_rdata_d = load_val;
         end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = load_val;
         end
      end
      if (state_d == WRITE) mem_din_d = merged;
      mem_we_d = (state_d == WRITE);
      busy_d   = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         starve_q   <= '0;
         owner_q    <= 1'b0;
         addr_q     <= '0;
         we_q       <= 1'b0;
         f3_q       <= '0;
         wdata_q    <= '0;
         lat_q      <= '0;
         rbytes_q   <= '{default: 8'd0};
         if_ack_q   <= 1'b0;
         d_ack_q    <= 1'b0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
         mem_we_q   <= 1'b0;
         mem_din_q  <= '{default: 8'd0};
         busy_q     <= 1'b0;
      end else begin
         starve_q   <= starve_d;
         owner_q    <= owner_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         f3_q       <= f3_d;
         wdata_q    <= wdata_d;
         lat_q      <= lat_d;
         rbytes_q   <= rbytes_d;
         if_ack_q   <= if_ack_d;
         d_ack_q    <= d_ack_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
         mem_we_q   <= mem_we_d;
         mem_din_q  <= mem_din_d;
         busy_q     <= busy_d;
      end
   end

   assign if_ack       = if_ack_q;
   assign if_rdata     = if_rdata_q;
   assign d_ack        = d_ack_q;
   assign d_rdata      = d_rdata_q;
   assign mem_addr     = addr_q;
   assign mem_write_en = mem_we_q;
   assign mem_data_in  = mem_din_q;
   assign busy         = busy_q;
   assign grant_d      = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vectors, corner sequences, random ops vs a byte-memory model.
module tb_mem_port_arbiter;
   import mem_port_pkg::*;

   localparam int MEM_LAT    = 1;
   localparam int STARVE_MAX = 4;

   logic        clk = 1'b0;
   logic        rst_b, if_req, d_req, d_we;
   logic [31:0] if_addr, d_addr, d_wdata;
   logic [2:0]  d_funct3;
   logic        if_ack, d_ack, mem_write_en, busy, grant_d;
   logic [31:0] if_rdata, d_rdata, mem_addr;
   logic [7:0]  mem_data_in  [0:3];
   logic [7:0]  mem_data_out [0:3];

   always #5 clk = ~clk;

   mem_port_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .rst_b(rst_b),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .mem_addr(mem_addr), .mem_write_en(mem_write_en),
      .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
      .busy(busy), .grant_d(grant_d)
   );

   // Byte-addressed memory with MEM_LAT-cycle registered read
   logic [7:0]  mem_arr [0:1023];
   logic [7:0]  ref_mem [0:1023];
   logic [31:0] rd_pipe [0:MEM_LAT-1];
   logic        pl_en = 1'b0;
   logic [9:0]  pl_addr;
   logic [31:0] pl_word;

   function automatic logic [31:0] mem_word(input logic [9:0] a);
      return {mem_arr[a + 10'd3], mem_arr[a + 10'd2], mem_arr[a + 10'd1], mem_arr[a]};
   endfunction

   always @(posedge clk) begin
      if (pl_en)
         for (int k = 0; k < 4; k++) mem_arr[pl_addr + 10'(k)] <= pl_word[8*k +: 8];
      if (mem_write_en)
         for (int k = 0; k < 4; k++) mem_arr[mem_addr[9:0] + 10'(k)] <= mem_data_in[k];
      rd_pipe[0] <= mem_word(mem_addr[9:0]);
      for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end

   always_comb
      for (int k = 0; k < 4; k++) mem_data_out[k] = rd_pipe[MEM_LAT-1][8*k +: 8];

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [9:0] a, input logic [31:0] w);
      pl_en = 1'b1; pl_addr = a; pl_word = w;
      @(posedge clk); #1;
      pl_en = 1'b0;
   endtask

   task automatic do_txn(input bit is_if, input bit we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output int lat, output int nwr, output bit tmo);
      bit started = 1'b0;
      lat = 0; nwr = 0; tmo = 1'b1; rdata = '0;
      if (is_if) begin
         if_req = 1'b1; if_addr = addr;
      end else begin
         d_req = 1'b1; d_we = we; d_funct3 = f3; d_addr = addr; d_wdata = wdata;
      end
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (mem_write_en) nwr++;
         if (started) lat++;
         else if (busy) started = 1'b1;
         if ((is_if && if_ack) || (!is_if && d_ack)) begin
            tmo = 1'b0;
            rdata = is_if ? if_rdata : d_rdata;
            break;
         end
      end
      if_req = 1'b0; d_req = 1'b0;
   endtask

   typedef struct {
      bit          we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] init;
      logic [31:0] exp_rd;
      logic [31:0] exp_mem;
      int          exp_lat;
      int          exp_nwr;
   } vec_t;

   vec_t vecs [0:10];

   logic [31:0] rd, exp_w;
   int          lat, nwr, nack;
   bit          tmo, prev_busy;
   int          gcnt, starve;
   bit          grants [$];

   initial begin
      vecs[0]  = '{1'b0, 3'd0, 32'h300, 32'h0,        32'h1234FF80, 32'hFFFFFF80, 32'h1234FF80, MEM_LAT+2, 0};
      vecs[1]  = '{1'b0, 3'd4, 32'h300, 32'h0,        32'h1234FF80, 32'h00000080, 32'h1234FF80, MEM_LAT+2, 0};
      vecs[2]  = '{1'b0, 3'd5, 32'h300, 32'h0,        32'h1234FF80, 32'h0000FF80, 32'h1234FF80, MEM_LAT+2, 0};
      vecs[3]  = '{1'b0, 3'd1, 32'h300, 32'h0,        32'h1234FF80, 32'hFFFFFF80, 32'h1234FF80, MEM_LAT+2, 0};
      vecs[4]  = '{1'b0, 3'd2, 32'h300, 32'h0,        32'h1234FF80, 32'h1234FF80, 32'h1234FF80, MEM_LAT+2, 0};
      vecs[5]  = '{1'b0, 3'd3, 32'h300, 32'h0,        32'h1234FF80, 32'h00000000, 32'h1234FF80, MEM_LAT+2, 0};
      vecs[6]  = '{1'b0, 3'd6, 32'h300, 32'h0,        32'h1234FF80, 32'h00000000, 32'h1234FF80, MEM_LAT+2, 0};
      vecs[7]  = '{1'b1, 3'd0, 32'h200, 32'h11223344, 32'hAABBCCDD, 32'h0,        32'hAABBCC44, MEM_LAT+3, 1};
      vecs[8]  = '{1'b1, 3'd1, 32'h200, 32'h11223344, 32'hAABBCCDD, 32'h0,        32'hAABB3344, MEM_LAT+3, 1};
      vecs[9]  = '{1'b1, 3'd2, 32'h200, 32'h11223344, 32'hAABBCCDD, 32'h0,        32'h11223344, 2,         1};
      vecs[10] = '{1'b1, 3'd5, 32'h200, 32'h11223344, 32'hAABBCCDD, 32'h0,        32'hAABBCCDD, 1,         0};

      rst_b = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_funct3 = 3'd0;
      if_addr = '0; d_addr = '0; d_wdata = '0;
      for (int a = 0; a < 1024; a += 4) preload(10'(a), $urandom);
      preload(10'h100, 32'h12345678);

      // Reset with both requesters asserted
      d_req = 1'b1; d_we = 1'b0; d_funct3 = F3_W; d_addr = 32'h100; if_req = 1'b1; if_addr = 32'h100;
      repeat (3) begin @(posedge clk); #1; end
      chk("rst_ctrl", {27'd0, busy, grant_d, if_ack, d_ack, mem_write_en}, 32'd0);
      chk("rst_if_rdata", if_rdata, 32'd0);
      chk("rst_d_rdata", d_rdata, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_din", {mem_data_in[3], mem_data_in[2], mem_data_in[1], mem_data_in[0]}, 32'd0);
      rst_b = 1'b1;
      @(posedge clk); #1;
      chk("rst_first_grant_d", {30'd0, busy, grant_d}, 32'd3);
      tmo = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (d_ack) begin tmo = 1'b0; break; end
         @(posedge clk); #1;
      end
      chk("rst_d_ack_timeout", 32'(tmo), 32'd0);
      chk("rst_d_rdata_after", d_rdata, 32'h12345678);
      d_req = 1'b0;
      tmo = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if (if_ack) begin tmo = 1'b0; break; end
      end
      chk("rst_if_ack_timeout", 32'(tmo), 32'd0);
      chk("rst_if_rdata_after", if_rdata, 32'h12345678);
      if_req = 1'b0;
      @(posedge clk); #1;

      // Fetch
      do_txn(1'b1, 1'b0, 3'd0, 32'h100, 32'h0, rd, lat, nwr, tmo);
      chk("fetch_timeout", 32'(tmo), 32'd0);
      chk("fetch_rdata", rd, 32'h12345678);
      chk("fetch_lat", 32'(lat), 32'(MEM_LAT + 2));
      chk("fetch_nwr", 32'(nwr), 32'd0);

      // Table-driven loads and stores
      for (int i = 0; i <= 10; i++) begin
         preload(vecs[i].addr[9:0], vecs[i].init);
         do_txn(1'b0, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, lat, nwr, tmo);
         chk($sformatf("vec%0d_timeout", i), 32'(tmo), 32'd0);
         if (!vecs[i].we) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
         chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
         chk($sformatf("vec%0d_nwr", i), 32'(nwr), 32'(vecs[i].exp_nwr));
         chk($sformatf("vec%0d_mem", i), mem_word(vecs[i].addr[9:0]), vecs[i].exp_mem);
      end

      // Contention: both requesters always pending
      d_req = 1'b1; d_we = 1'b0; d_funct3 = F3_W; d_addr = 32'h0;
      if_req = 1'b1; if_addr = 32'h4;
      prev_busy = 1'b0; gcnt = 0;
      for (int c = 0; c < 200 && gcnt < 10; c++) begin
         @(posedge clk); #1;
         if (busy && !prev_busy) begin grants.push_back(grant_d); gcnt++; end
         prev_busy = busy;
      end
      d_req = 1'b0; if_req = 1'b0;
      repeat (8) begin @(posedge clk); #1; end
      chk("contend_grant_count", 32'(gcnt), 32'd10);
      starve = 0;
      for (int i = 0; i < 10 && i < gcnt; i++) begin
         bit exp_d;
         exp_d = (starve < STARVE_MAX);
         starve = exp_d ? starve + 1 : 0;
         chk($sformatf("contend_grant%0d", i), 32'(grants[i]), 32'(exp_d));
      end

      // Reset while an SH waits on read data
      preload(10'h200, 32'hAABBCCDD);
      d_req = 1'b1; d_we = 1'b1; d_funct3 = F3_H; d_addr = 32'h200; d_wdata = 32'h55667788;
      tmo = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if (busy) begin tmo = 1'b0; break; end
      end
      chk("rstmid_grant_timeout", 32'(tmo), 32'd0);
      rst_b = 1'b0; d_req = 1'b0;
      @(posedge clk); #1;
      chk("rstmid_idle", {29'd0, busy, mem_write_en, d_ack}, 32'd0);
      rst_b = 1'b1;
      nwr = 0; nack = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (mem_write_en) nwr++;
         if (d_ack || if_ack) nack++;
      end
      chk("rstmid_no_write", 32'(nwr), 32'd0);
      chk("rstmid_no_ack", 32'(nack), 32'd0);
      chk("rstmid_mem", mem_word(10'h200), 32'hAABBCCDD);
      do_txn(1'b0, 1'b1, F3_W, 32'h200, 32'h99887766, rd, lat, nwr, tmo);
      chk("rstmid_sw_timeout", 32'(tmo), 32'd0);
      chk("rstmid_sw_lat", 32'(lat), 32'd2);
      chk("rstmid_sw_nwr", 32'(nwr), 32'd1);
      chk("rstmid_sw_mem", mem_word(10'h200), 32'h99887766);

      // Random operations against a byte-level reference memory
      for (int a = 0; a < 1024; a++) ref_mem[a] = mem_arr[a];
      for (int n = 0; n < 60; n++) begin
         bit          is_if, we;
         logic [2:0]  f3;
         logic [9:0]  a;
         logic [31:0] wd, w, exp_rd;
         int          nb, exp_lat;
         is_if = ($urandom_range(0, 3) == 0);
         we    = is_if ? 1'b0 : 1'($urandom_range(0, 1));
         f3    = 3'($urandom_range(0, 7));
         a     = 10'($urandom_range(0, 1019));
         wd    = $urandom;
         w     = {ref_mem[a + 10'd3], ref_mem[a + 10'd2], ref_mem[a + 10'd1], ref_mem[a]};
         exp_rd = 32'd0;
         if (is_if || f3 == 3'd2) exp_rd = w;
         else if (f3 == 3'd0) exp_rd = (w[7:0] >= 8'd128) ? 32'(int'(w[7:0]) - 256) : 32'(w[7:0]);
         else if (f3 == 3'd1) exp_rd = (w[15:0] >= 16'd32768) ? 32'(int'(w[15:0]) - 65536) : 32'(w[15:0]);
         else if (f3 == 3'd4) exp_rd = w % 256;
         else if (f3 == 3'd5) exp_rd = w % 65536;
         nb = !we ? 0 : (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
         if (!we)             exp_lat = MEM_LAT + 2;
         else if (f3 == 3'd2) exp_lat = 2;
         else if (f3 < 3'd2)  exp_lat = MEM_LAT + 3;
         else                 exp_lat = 1;
         do_txn(is_if, we, f3, 32'(a), wd, rd, lat, nwr, tmo);
         chk($sformatf("rnd%0d_timeout", n), 32'(tmo), 32'd0);
         chk($sformatf("rnd%0d_lat", n), 32'(lat), 32'(exp_lat));
         chk($sformatf("rnd%0d_nwr", n), 32'(nwr), (nb > 0) ? 32'd1 : 32'd0);
         if (!we) chk($sformatf("rnd%0d_rdata", n), rd, exp_rd);
         for (int k = 0; k < nb; k++) ref_mem[a + 10'(k)] = wd[8*k +: 8];
         if (we) begin
            exp_w = {ref_mem[a + 10'd3], ref_mem[a + 10'd2], ref_mem[a + 10'd1], ref_mem[a]};
            chk($sformatf("rnd%0d_mem", n), mem_word(a), exp_w);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences the single shared byte-lane data memory port between instruction fetch (IF) and the load/store path (D).
- Performs read-modify-write for SB/SH, and sign- or zero-extension for LB/LH/LW/LBU/LHU.
- Sits between the fetch unit / execute stage and the memory. All requests use a req/ack handshake.

Parameters:
- MEM_LAT, 1, memory read latency in cycles from mem_addr valid to mem_data_out valid; legal range 1..4.
- STARVE_MAX, 4, maximum consecutive D grants while if_req is pending before IF is forced.

Ports:
- clk  in  1  clock, rising edge
- rst_b  in  1  synchronous active-low reset
- if_req  in  1  fetch request; held with if_addr until if_ack
- if_addr  in  32  fetch byte address
- if_ack  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  32  fetched word
- d_req  in  1  data request; held with d_we/d_funct3/d_addr/d_wdata until d_ack
- d_we  in  1  1=store, 0=load
- d_funct3  in  3  RV32 width code
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_ack  out  1  one-cycle pulse; d_rdata valid for loads
- d_rdata  out  32  extended load result
- mem_addr  out  32  memory address
- mem_write_en  out  1  memory write strobe
- mem_data_in  out  8 x [0:3]  write bytes; lane 0 = LSB
- mem_data_out  in  8 x [0:3]  read bytes
- busy  out  1  FSM not in IDLE
- grant_d  out  1  current owner: 1=D, 0=IF

Behaviour:
- Reset:
  - While rst_b=0 at a clk edge: state=IDLE, starve_cnt=0.
  - All outputs are 0, including mem_write_en, both acks and both rdata buses.
  - Reset mid-operation abandons the transaction: no write, no ack. mem_write_en is 0 from the next cycle.
- All outputs are registered.
- FSM states: IDLE, RD_WAIT, WRITE, RESP.
- IDLE arbitration:
  - Only d_req: grant D.
  - Only if_req: grant IF.
  - Both: grant D, unless starve_cnt==STARVE_MAX, in which case grant IF.
  - Neither: stay in IDLE.
  - On grant, latch addr, we, funct3 and wdata, and drive mem_addr.
- starve_cnt:
  - Increments on each D grant made while if_req=1.
  - Clears on any IF grant, or when IF is idle (if_req=0) at a D grant.
  - Saturates at STARVE_MAX.
- Transitions from IDLE:
  - Fetch, load, or store with funct3 0/1: go to RD_WAIT.
  - SW (funct3=2): go to WRITE.
  - Store with funct3 3..7: go directly to RESP; no write is performed.
- RD_WAIT:
  - Counts MEM_LAT cycles, then captures mem_data_out.
  - Loads and fetches then go to RESP; SB/SH go to WRITE.
- Load formatting from the captured bytes b0..b3 (lane-relative to the address; misaligned addresses pass through unchanged):
  - LB: sign-extend b0.
  - LH: sign-extend {b1,b0}.
  - LW: {b3,b2,b1,b0}.
  - LBU: zero-extend b0.
  - LHU: zero-extend {b1,b0}.
  - funct3 3/6/7: result is 0.
  - Fetch always uses LW formatting.
- WRITE:
  - mem_write_en=1 for exactly one cycle, then go to RESP.
  - Lane 0 always takes wdata[7:0].
  - Lane 1 takes wdata[15:8] for SH/SW, otherwise the old byte.
  - Lanes 2..3 take wdata for SW, otherwise the old bytes.
- RESP:
  - Asserts the granted requester's ack for one cycle with rdata; the other ack stays 0.
  - Next state is IDLE, so a request sampled in IDLE is always a new request.
- rdata holds its value until the next ack to the same requester.
- Latency, counted from the grant edge to the ack-high edge:
  - SW: 2 cycles.
  - Load and fetch: MEM_LAT+2 cycles.
  - SB/SH: MEM_LAT+3 cycles.
- Exactly one transaction is in flight; there is no pipelining.
- mem_write_en is never asserted outside WRITE.

Decomposition:
- Package mem_port_pkg holds:
  - state_t enum (IDLE, RD_WAIT, WRITE, RESP).
  - funct3 constants F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5.
  - byte_lane_t type: 8-bit x [0:3].
- Sub-module mem_lane_fmt (combinational): load extension plus store byte-merge. The FSM, counters and arbitration stay in the top module.

Test Plan:
- Reset: hold rst_b=0 for 3 cycles while if_req=d_req=1 -> all outputs 0, no ack, busy=0. Release -> D is granted first.
- Fetch, MEM_LAT=1: if_addr=0x100, memory bytes {78,56,34,12} -> if_ack high 3 cycles after the grant, if_rdata=0x12345678, mem_write_en stays 0.
- Loads on byte0=0x80, byte1=0xFF:
  - LB -> d_rdata=0xFFFFFF80.
  - LBU -> 0x00000080.
  - LHU -> 0x0000FF80.
- SB read-modify-write: old word 0xAABBCCDD at 0x200, d_wdata=0x11223344, funct3=0 -> a single mem_write_en pulse with lanes {44,CC,BB,AA}. d_ack arrives MEM_LAT+3 cycles after the grant.
- Contention, STARVE_MAX=4: d_req and if_req both held high, requests re-presented after each ack -> grant order D,D,D,D,IF,D,D,D,D,IF.
- Reset in RD_WAIT of an SH -> no mem_write_en pulse, no d_ack, IDLE next cycle. A subsequent SW to the same address completes normally.
